// File: rtl/alu_seq24.sv
// 24-bit sequential execution unit: single-cycle logic/arith ops plus an
// iterative radix-2 shift-add multiplier with a Busy/Done handshake.
module alu_seq24 #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mplr_q, acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic signed [WIDTH-1:0] sa, sb, sum_s, diff_s;
  logic [WIDTH-1:0]        res_c, acc_next;
  logic                    ovf_c, mul_last;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign sa     = $signed(A);
  assign sb     = $signed(B);
  assign sum_s  = sa + sb;
  assign diff_s = sa - sb;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (ALUCtrl)
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      OP_XOR: res_c = A ^ B;
      OP_ADD: begin
        res_c = sum_s;
        ovf_c = add_ovf(sa, sb, sum_s);
      end
      OP_SUB: begin
        res_c = diff_s;
        ovf_c = sub_ovf(sa, sb, diff_s);
      end
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, (sa < sb)};
      // shift amounts >= WIDTH shift everything out, giving zero
      OP_SLL: res_c = A << B[SHW-1:0];
      default: res_c = '0;
    endcase
  end

  assign acc_next = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign mul_last = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH-1));
  assign Busy     = (state_q == MUL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start && (ALUCtrl == OP_MUL)) state_d = MUL;
      MUL:  if (mul_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Result   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      Done <= 1'b0;
      if (state_q == IDLE && Start) begin
        Zero <= (A == B);
        if (ALUCtrl == OP_MUL) begin
          mcand_q <= A;
          mplr_q  <= B;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          Result   <= res_c;
          Overflow <= ovf_c;
          Done     <= 1'b1;
        end
      end else if (state_q == MUL) begin
        // one shift-add iteration per clock; finish on the 24th
        acc_q   <= acc_next;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (mul_last) begin
          Result   <= acc_next;
          Overflow <= 1'b0;
          Done     <= 1'b1;
          cnt_q    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq24.sv
// Directed bench for alu_seq24: single-cycle ops, signed flags, MUL timing,
// asynchronous reset abort and back-to-back Start in the Done cycle.
module tb_alu_seq24;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Start;
  logic [3:0]  ALUCtrl;
  logic [23:0] A, B;
  logic [23:0] Result;
  logic        Zero, Overflow, Busy, Done;

  int checks = 0;
  int errors = 0;

  alu_seq24 #(.WIDTH(24), .SHW(5)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .ALUCtrl(ALUCtrl),
    .A(A), .B(B), .Result(Result), .Zero(Zero), .Overflow(Overflow),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a Start for one edge; returns #1 after that edge.
  task automatic op(input logic [3:0] c, input logic [23:0] a, input logic [23:0] b);
    Start = 1'b1; ALUCtrl = c; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    ResetN = 1'b0; Start = 1'b0; ALUCtrl = 4'b0000; A = '0; B = '0;
    tick(); tick();
    chk24("rst_result", Result, 24'h0);
    chk1("rst_zero", Zero, 1'b0);
    chk1("rst_ovf", Overflow, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    ResetN = 1'b1;
    tick();

    // ADD to get a nonzero Result before the aborted MUL
    op(4'b0010, 24'd5, 24'd7);
    chk24("add_pre", Result, 24'd12);
    chk1("add_pre_done", Done, 1'b1);
    tick();
    chk1("add_pre_done_off", Done, 1'b0);

    // MUL aborted by reset at cycle 10
    op(4'b0100, 24'd1000, 24'd3000);
    chk1("abort_busy_on", Busy, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    #2 ResetN = 1'b0;
    #1;
    chk1("abort_busy", Busy, 1'b0);
    chk24("abort_result", Result, 24'h0);
    chk1("abort_done", Done, 1'b0);
    chk1("abort_zero", Zero, 1'b0);
    tick();
    ResetN = 1'b1;
    tick();
    op(4'b0010, 24'd5, 24'd7);
    chk24("post_add", Result, 24'd12);
    chk1("post_add_done", Done, 1'b1);
    chk1("post_add_busy", Busy, 1'b0);
    tick();
    chk1("post_add_done_off", Done, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        chk1("post_abort_quiet", Done | Busy, 1'b0);
        break;
      end
    end
    chk24("post_abort_hold", Result, 24'd12);

    // single-cycle logic ops
    op(4'b0000, 24'h00F0F0, 24'h0F0F00); chk24("and", Result, 24'h000000);
    op(4'b0001, 24'h00F0F0, 24'h0F0F00); chk24("or", Result, 24'h0FFFF0);
    op(4'b0101, 24'h00F0F0, 24'h0F0F00); chk24("xor", Result, 24'h0FFFF0);
    op(4'b1111, 24'h00F0F0, 24'h0F0F00); chk24("unknown", Result, 24'h000000);
    chk1("unknown_done", Done, 1'b1);
    op(4'b0110, 24'd1, 24'd23);          chk24("sll23", Result, 24'h800000);
    op(4'b0110, 24'd1, 24'd24);          chk24("sll24", Result, 24'h000000);

    // signed arithmetic
    op(4'b0010, 24'h7FFFFF, 24'h000001);
    chk24("add_ovf_res", Result, 24'h800000);
    chk1("add_ovf", Overflow, 1'b1);
    op(4'b1010, 24'h800000, 24'h000001);
    chk24("sub_ovf_res", Result, 24'h7FFFFF);
    chk1("sub_ovf", Overflow, 1'b1);
    op(4'b0011, 24'hFFFFFF, 24'h000001);
    chk24("slt_neg", Result, 24'h000001);
    chk1("slt_ovf", Overflow, 1'b0);
    op(4'b0011, 24'h000001, 24'hFFFFFF);
    chk24("slt_pos", Result, 24'h000000);
    op(4'b1010, 24'h123456, 24'h123456);
    chk24("sub_eq_res", Result, 24'h000000);
    chk1("sub_eq_zero", Zero, 1'b1);
    chk1("sub_eq_ovf", Overflow, 1'b0);
    op(4'b0010, 24'hFFFFFF, 24'h000001);
    chk24("add_wrap", Result, 24'h000000);
    chk1("add_wrap_ovf", Overflow, 1'b0);
    chk1("add_wrap_zero", Zero, 1'b0);

    // MUL 1000*3000, with ignored Start/operands while Busy
    op(4'b0100, 24'd1000, 24'd3000);
    chk1("mul_busy_k", Busy, 1'b1);
    chk1("mul_done_k", Done, 1'b0);
    for (int i = 1; i <= 23; i++) begin
      if (i == 2) begin
        Start = 1'b1; ALUCtrl = 4'b0010; A = 24'h000111; B = 24'h000222;
      end
      if (i == 3) begin
        Start = 1'b1; ALUCtrl = 4'b0100; A = 24'h000007; B = 24'h000009;
      end
      if (i == 4) Start = 1'b0;
      tick();
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        chk1("mul_busy_window", Busy & ~Done, 1'b1);
        break;
      end
      if (i == 23) begin
        chk1("mul_busy_k23", Busy, 1'b1);
        chk24("mul_result_hold", Result, 24'h000000);
      end
    end
    tick();
    chk1("mul_done", Done, 1'b1);
    chk1("mul_busy_off", Busy, 1'b0);
    chk24("mul_result", Result, 24'h2DC6C0);
    chk1("mul_ovf", Overflow, 1'b0);
    chk1("mul_zero", Zero, 1'b0);
    tick();
    chk1("mul_done_off", Done, 1'b0);
    chk24("mul_result_keep", Result, 24'h2DC6C0);

    // MUL wrap
    op(4'b0100, 24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 24; i++) tick();
    chk1("mulw_done", Done, 1'b1);
    chk24("mulw_result", Result, 24'h000001);
    chk1("mulw_zero", Zero, 1'b1);

    // BNE compare, then back-to-back Start in the Done cycle
    tick();
    op(4'b0110, 24'd3, 24'd3);
    chk24("bne_result", Result, 24'd24);
    chk1("bne_zero", Zero, 1'b1);
    chk1("bne_done", Done, 1'b1);
    op(4'b0010, 24'd1, 24'd2);
    chk24("b2b_result", Result, 24'd3);
    chk1("b2b_done", Done, 1'b1);
    chk1("b2b_zero", Zero, 1'b0);
    tick();
    chk1("b2b_done_off", Done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq24.md
Name: alu_seq24

Overview:
- Sequential 24-bit execution unit. It consumes the 4-bit ALUCtrl code produced by the ALU control decoder and executes the selected operation on two register operands.
- Single-cycle operations complete one clock after Start. MUL runs as an iterative radix-2 shift-add over 24 clocks, with a Busy/Done handshake the datapath uses to stall the PC.
- Sits between the register-file read ports and the writeback/branch logic.

Parameters:
- WIDTH, 24, operand and result width in bits.
- SHW, 5, width of the shift-amount field taken from B[SHW-1:0].

Ports:
- Clock  input  1  rising-edge clock.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  request to execute; sampled only in IDLE.
- ALUCtrl  input  4  operation code.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Result  output  WIDTH  registered result.
- Zero  output  1  registered; 1 when the latched A equals the latched B.
- Overflow  output  1  registered; signed overflow for ADD/SUB, else 0.
- Busy  output  1  high while a MUL is in progress.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (ResetN=0, takes effect immediately):
  - State=IDLE.
  - Result=0, Zero=0, Overflow=0, Busy=0, Done=0.
  - Multiplier accumulator and counter cleared.
  - A reset during MUL aborts the operation; no Done is produced.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 1010 SUB, 0011 SLT, 0100 MUL, 0101 XOR, 0110 SLL.
  - Any other code: Result=0, Overflow=0, completes as single-cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^24, two's complement.
  - Overflow=1 when operand signs and result sign show signed overflow. For SUB this means A and B have different signs and the result sign differs from A.
  - SLT is signed: Result=24'h000001 if $signed(A)<$signed(B), else 0.
  - SLL: Result=A<<B[4:0]. A shift amount of 24..31 gives 0.
  - MUL: Result = low 24 bits of A*B (unsigned; identical low bits for signed). Overflow=0.
  - Zero = (A==B) on the latched operands for every op code, including 0110. This is the flag used by BNE.
- States: IDLE, MUL.
- IDLE:
  - Start=1 with a non-MUL code at edge k: Result, Zero and Overflow update at edge k. Done=1 for the cycle following edge k. State stays IDLE, Busy stays 0.
  - Start=1 with ALUCtrl=0100 at edge k:
    - Latch multiplicand=A, multiplier=B and Zero=(A==B).
    - Clear accumulator, counter=0.
    - State->MUL, Busy=1.
- MUL:
  - Each edge: if multiplier[0], accumulator += multiplicand (mod 2^24). Then multiplicand<<=1, multiplier>>=1, counter++.
  - On the edge where counter reaches 23 (the 24th iteration, edge k+24):
    - Result=final accumulator.
    - Done=1 for one cycle, Busy=0, state->IDLE.
  - Start, ALUCtrl, A and B are ignored during MUL. Operands are latched only at edge k.
- Done:
  - Exactly one cycle wide per accepted Start.
  - Start may be asserted again in the Done cycle (state is IDLE) and is accepted normally.
- Result, Zero and Overflow hold their values until the next completion. They do not change while Busy.
- Start=0 in IDLE: no output changes. Done=0.

Test Plan:
- Reset mid-stream: assert ResetN=0 during MUL cycle 10 -> all outputs 0 immediately. Release, then Start ADD A=5, B=7 -> Result=12 one cycle later, Done pulses once, Busy never rises.
- Single-cycle ops: A=24'h00F0F0, B=24'h0F0F00, codes AND/OR/XOR -> 24'h000000 / 24'h0FFFF0 / 24'h0FFFF0. SLL with A=1, B=23 -> 24'h800000; with B=24 -> 0. Unknown code 1111 -> 0.
- Signed arithmetic:
  - ADD 24'h7FFFFF+1 -> Result 24'h800000, Overflow=1.
  - SUB 24'h800000-1 -> 24'h7FFFFF, Overflow=1.
  - SLT A=24'hFFFFFF (-1), B=1 -> 1.
  - SUB A=B=24'h123456 -> Result 0, Zero=1.
- MUL timing and value: Start MUL A=1000, B=3000 at edge k.
  - Busy=1 edges k..k+24; Done only after edge k+24; Result=3000000 (24'h2DC6C0).
  - Change A/B and pulse Start during Busy -> no effect on Result.
- MUL wrap: A=24'hFFFFFF, B=24'hFFFFFF -> Result 24'h000001.
- BNE compare: ALUCtrl=0110, A=3, B=3 -> Zero=1, Result=24. Back-to-back Start in the Done cycle is accepted, giving two Done pulses on consecutive completions.
